cdc_handshake_tx: RTL and testbench

Source-domain transmitter of a toggle-based req/ack bus-crossing handshake. Accepts one word per transfer over a valid/ready interface, holds it stable on `data_o`, and toggles `req_o`. It waits for the destination's `ack_i` toggle to come back through an internal synchronizer before accepting the next word. `data_o`/`req_o` feed the destination-domain receiver, which captures `data_o` after its own `req` synchronizer sees the toggle.

---
 rtl/cdc_handshake_tx.sv | 94 +++++++++
 tb/tb_cdc_handshake_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cdc_handshake_tx: source side of a toggle req/ack bus-crossing handshake.  |
// | Option macro: CDC_TX_ACK_SYNC_EN (ack_i synchronizer chain present).        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module cdc_handshake_tx #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  req_o,
  input  logic                  ack_i,
  output logic                  done_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  xfer_cnt_o,
  output logic                  proto_err_o
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  state_t r_state;
  logic   w_ack_s;

  generate
    if (SYNC_STAGES < 2) begin : g_sync_stages_check
      $error("cdc_handshake_tx: SYNC_STAGES must be at least 2");
    end
  endgenerate

`ifdef CDC_TX_ACK_SYNC_EN
  logic [SYNC_STAGES-1:0] r_ack_sync;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_i};
    end
  end

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
`else
  assign w_ack_s = ack_i;
`endif

  assign s_ready_o = (r_state == ST_IDLE);
  assign busy_o    = (r_state == ST_WAIT_ACK);

  // data_o only moves on an accept, so it is stable for the whole round trip
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state     <= ST_IDLE;
      data_o      <= '0;
      req_o       <= 1'b0;
      done_o      <= 1'b0;
      xfer_cnt_o  <= '0;
      proto_err_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ack_s != req_o) begin
            proto_err_o <= 1'b1;
          end
          if (s_valid_i) begin
            data_o  <= s_data_i;
            req_o   <= ~req_o;
            r_state <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (w_ack_s == req_o) begin
            r_state    <= ST_IDLE;
            done_o     <= 1'b1;
            xfer_cnt_o <= xfer_cnt_o + CNT_WIDTH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cdc_handshake_tx: directed self-checking bench for cdc_handshake_tx.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_cdc_handshake_tx;

  localparam int c_sync = 2;
`ifdef CDC_TX_ACK_SYNC_EN
  localparam int c_lat = c_sync + 1;
`else
  localparam int c_lat = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid;
  logic [31:0] s_data;
  logic        ack;
  logic        s_ready, req, done, busy, proto_err;
  logic [31:0] data;
  logic [15:0] xfer_cnt;

  // small-counter instance used to exercise the counter wrap cheaply
  logic        s_valid2;
  logic [7:0]  s_data2;
  logic        ack2;
  logic        s_ready2, req2, done2, busy2, proto_err2;
  logic [7:0]  data2;
  logic [3:0]  xfer_cnt2;

  int n_checks = 0;
  int n_fail   = 0;
  logic        exp_req;
  logic [31:0] exp_data;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  cdc_handshake_tx #(.DATA_WIDTH(32), .SYNC_STAGES(c_sync), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rstn_i(rstn), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .data_o(data), .req_o(req), .ack_i(ack),
    .done_o(done), .busy_o(busy), .xfer_cnt_o(xfer_cnt), .proto_err_o(proto_err)
  );

  cdc_handshake_tx #(.DATA_WIDTH(8), .SYNC_STAGES(c_sync), .CNT_WIDTH(4)) dut2 (
    .clk_i(clk), .rstn_i(rstn), .s_valid_i(s_valid2), .s_ready_o(s_ready2),
    .s_data_i(s_data2), .data_o(data2), .req_o(req2), .ack_i(ack2),
    .done_o(done2), .busy_o(busy2), .xfer_cnt_o(xfer_cnt2), .proto_err_o(proto_err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    ack  = 1'b0;
    ack2 = 1'b0;
    s_valid = 1'b0;
    s_valid2 = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    exp_req  = 1'b0;
    exp_data = 32'h0;
    exp_cnt  = 32'h0;
  endtask

  task automatic xfer(input logic [31:0] d, input bit hold);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    tick();
    exp_req  = ~exp_req;
    exp_data = d;
    check("req_after_accept", {31'b0, req}, {31'b0, exp_req});
    check("data_after_accept", data, d);
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    check("ready_after_accept", {31'b0, s_ready}, 32'd0);
    if (hold) s_data = ~d;
    else s_valid = 1'b0;
    repeat (3) begin
      tick();
      check("data_held", data, d);
      check("req_held", {31'b0, req}, {31'b0, exp_req});
      check("no_early_done", {31'b0, done}, 32'd0);
    end
    ack = exp_req;
    wait_done(n);
    exp_cnt = exp_cnt + 1;
    check("done_latency", n, c_lat);
    check("ready_at_done", {31'b0, s_ready}, 32'd1);
    check("cnt_at_done", {16'b0, xfer_cnt}, exp_cnt);
    check("data_at_done", data, d);
    s_valid = 1'b0;
  endtask

  initial begin
    int k;
    s_data  = 32'h0;
    s_data2 = 8'h0;
    do_reset();

    // idle after reset
    repeat (10) tick();
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_ready", {31'b0, s_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_cnt", {16'b0, xfer_cnt}, 32'd0);
    check("rst_err", {31'b0, proto_err}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);

    // single word
    xfer(32'hDEADBEEF, 1'b0);
    tick();
    check("done_one_pulse", {31'b0, done}, 32'd0);
    check("data_after_done", data, 32'hDEADBEEF);

    // back-to-back words with valid held and data changing during WAIT_ACK
    do_reset();
    tick();
    xfer(32'h11111111, 1'b1);
    xfer(32'h22222222, 1'b1);
    xfer(32'h33333333, 1'b1);
    xfer(32'h44444444, 1'b1);
    tick();
    check("four_cnt", {16'b0, xfer_cnt}, 32'd4);
    check("four_req", {31'b0, req}, 32'd0);
    check("four_err", {31'b0, proto_err}, 32'd0);

    // ack toggles with nothing outstanding
    ack = 1'b1;
    k = 0;
    while (!proto_err && k < 30) begin
      tick();
      k++;
    end
    check("err_latency", k, c_lat);
    repeat (3) tick();
    check("err_sticky", {31'b0, proto_err}, 32'd1);
    check("err_req_kept", {31'b0, req}, 32'd0);
    check("err_data_kept", data, 32'h44444444);
    ack = 1'b0;
    repeat (c_lat + 1) tick();
    check("err_after_ack_back", {31'b0, proto_err}, 32'd1);
    xfer(32'hCAFEF00D, 1'b0);
    check("err_through_xfer", {31'b0, proto_err}, 32'd1);
    do_reset();
    tick();
    check("err_cleared", {31'b0, proto_err}, 32'd0);
    check("cnt_cleared", {16'b0, xfer_cnt}, 32'd0);

    // reset while waiting for ack
    s_valid = 1'b1;
    s_data  = 32'h12345678;
    tick();
    s_valid = 1'b0;
    check("mid_req_set", {31'b0, req}, 32'd1);
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("mid_rst_req", {31'b0, req}, 32'd0);
    check("mid_rst_data", data, 32'd0);
    check("mid_rst_ready", {31'b0, s_ready}, 32'd1);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    repeat (c_lat + 2) tick();
    check("mid_rst_no_err", {31'b0, proto_err}, 32'd0);

    // counter wrap on the 4-bit instance
    for (int i = 0; i < 16; i++) begin
      s_valid2 = 1'b1;
      s_data2  = 8'(i);
      tick();
      s_valid2 = 1'b0;
      ack2 = ~ack2;
      k = 0;
      while (!done2 && k < 30) begin
        tick();
        k++;
      end
      if (i == 14) check("wrap_cnt_max", {28'b0, xfer_cnt2}, 32'hF);
      if (i == 15) check("wrap_cnt_zero", {28'b0, xfer_cnt2}, 32'h0);
    end
    check("wrap_done_latency", k, c_lat);
    check("wrap_err", {31'b0, proto_err2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
